// File: rtl/servo_pkg.sv
// Shared codes, state encodings and helpers for the multi-channel servo controller.
package servo_pkg;

  // Width of every counter and pulse-width value in the design.
  localparam int CNT_W = 32;

  // Frame header and broadcast channel codes on the serial link.
  localparam logic [7:0] HDR_CODE   = 8'hFF;
  localparam logic [7:0] BCAST_CODE = 8'hFE;

  // Command parser states.
  typedef enum logic [1:0] {
    P_HUNT,
    P_CHAN,
    P_POS
  } parser_state_t;

  // UART receiver states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Pulse width in clocks for a given 8-bit position.
  function automatic logic [CNT_W-1:0] pulse_width(input logic [7:0] pos,
                                                    input int pmin,
                                                    input int pstep);
    return CNT_W'(pmin) + CNT_W'(pos) * CNT_W'(pstep);
  endfunction

endpackage

// File: rtl/servo_uart_rx.sv
// 8N1 UART receiver: input synchroniser, false-start rejection,
// mid-bit sampling, one-cycle byte strobe and stop-bit error strobe.
module servo_uart_rx
  import servo_pkg::*;
#(
  parameter int BAUD_TICK = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_stop_err
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(BAUD_TICK - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_TICK / 2 - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_valid;
  logic             r_stop_err;
  logic             w_fall;

  // A start is only recognised on a falling edge, so a line stuck low
  // after a framing error cannot retrigger reception.
  assign w_fall = r_sync3 & ~r_sync2;

  // Two-flop synchroniser plus one extra stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Bit-timing state machine; strobes are registered one cycle after the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_valid    <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_stop_err <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == TICK_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
            else r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == TICK_LAST) begin
            r_cnt      <= '0;
            r_state    <= RX_IDLE;
            r_valid    <= r_sync2;
            r_stop_err <= ~r_sync2;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_byte     = r_shift;
  assign o_valid    = r_valid;
  assign o_stop_err = r_stop_err;

endmodule

// File: rtl/multi_servo_uart_ctrl.sv
// Multi-channel servo controller: UART command frames (FF, channel, position)
// set per-channel targets; positions slew toward targets and drive PWM outputs.
module multi_servo_uart_ctrl
  import servo_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int NUM_CH     = 4,
  parameter int PWM_PERIOD = 1000000,
  parameter int PULSE_MIN  = 50000,
  parameter int PULSE_STEP = 196,
  parameter int SLEW_DIV   = 25000,
  parameter int CENTER     = 128
) (
  input  logic              clk50mhz,
  input  logic              rst,
  input  logic              uart_rx,
  output logic [NUM_CH-1:0] servo_pwm_out,
  output logic              cmd_valid,
  output logic              frame_err
);

  localparam int               BAUD_TICK = CLK_FREQ / BAUD_RATE;
  localparam logic [7:0]       NUM_CH_B  = 8'(NUM_CH);
  localparam logic [7:0]       CENTER_B  = 8'(CENTER);
  localparam logic [CNT_W-1:0] PWM_LAST  = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] SLEW_LAST = CNT_W'(SLEW_DIV - 1);
  localparam logic [CNT_W-1:0] RST_WIDTH = CNT_W'(PULSE_MIN + CENTER * PULSE_STEP);

  logic [7:0]       w_byte;
  logic             w_byte_valid;
  logic             w_stop_err;
  logic             w_pos_wr;
  logic             w_slew_tick;
  logic             w_pwm_zero;
  parser_state_t    r_state;
  logic [7:0]       r_chan;
  logic             r_cmd_valid;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_slew_cnt;
  logic [CNT_W-1:0] r_pwm_cnt;

  servo_uart_rx #(
    .BAUD_TICK(BAUD_TICK)
  ) u_rx (
    .clk       (clk50mhz),
    .rst       (rst),
    .i_rx      (uart_rx),
    .o_byte    (w_byte),
    .o_valid   (w_byte_valid),
    .o_stop_err(w_stop_err)
  );

  // Frame parser: header hunt, channel latch, position write.
  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      r_state     <= P_HUNT;
      r_chan      <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_frame_err <= w_stop_err;
      if (w_stop_err) begin
        r_state <= P_HUNT;
      end else if (w_byte_valid) begin
        case (r_state)
          P_HUNT: if (w_byte == HDR_CODE) r_state <= P_CHAN;
          P_CHAN: begin
            if (w_byte == HDR_CODE) begin
              r_state <= P_CHAN;
            end else if (w_byte < NUM_CH_B || w_byte == BCAST_CODE) begin
              r_chan  <= w_byte;
              r_state <= P_POS;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= P_HUNT;
            end
          end
          P_POS: begin
            if (w_byte == HDR_CODE) begin
              r_state <= P_CHAN;
            end else begin
              r_cmd_valid <= 1'b1;
              r_state     <= P_HUNT;
            end
          end
          default: r_state <= P_HUNT;
        endcase
      end
    end
  end

  // A position byte (anything but a header) in POS commits the command.
  assign w_pos_wr  = w_byte_valid && (r_state == P_POS) && (w_byte != HDR_CODE);
  assign cmd_valid = r_cmd_valid;
  assign frame_err = r_frame_err;

  // Free-running slew divider and PWM frame counter.
  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      r_slew_cnt <= '0;
      r_pwm_cnt  <= '0;
    end else begin
      r_slew_cnt <= (r_slew_cnt == SLEW_LAST) ? '0 : r_slew_cnt + 1'b1;
      r_pwm_cnt  <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
    end
  end

  assign w_slew_tick = (r_slew_cnt == SLEW_LAST);
  assign w_pwm_zero  = (r_pwm_cnt == '0);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [7:0]       r_target;
    logic [7:0]       r_pos;
    logic [CNT_W-1:0] r_width;
    logic             r_pwm;
    logic             w_hit;

    assign w_hit = w_pos_wr && (r_chan == BCAST_CODE || r_chan == 8'(gi));

    // Target register; a same-cycle slew tick still sees the previous target.
    always_ff @(posedge clk50mhz or posedge rst) begin
      if (rst) r_target <= CENTER_B;
      else if (w_hit) r_target <= w_byte;
    end

    // Position moves one LSB toward the target on each slew tick.
    always_ff @(posedge clk50mhz or posedge rst) begin
      if (rst) begin
        r_pos <= CENTER_B;
      end else if (w_slew_tick) begin
        if (r_pos < r_target) r_pos <= r_pos + 1'b1;
        else if (r_pos > r_target) r_pos <= r_pos - 1'b1;
      end
    end

    // Width is captured only at frame start so a pulse in flight never changes length.
    always_ff @(posedge clk50mhz or posedge rst) begin
      if (rst) begin
        r_width <= RST_WIDTH;
        r_pwm   <= 1'b0;
      end else begin
        if (w_pwm_zero) r_width <= pulse_width(r_pos, PULSE_MIN, PULSE_STEP);
        r_pwm <= (r_pwm_cnt < r_width);
      end
    end

    assign servo_pwm_out[gi] = r_pwm;
  end

endmodule

// File: tb/tb_multi_servo_uart_ctrl.sv
// Directed bench for multi_servo_uart_ctrl using scaled-down timing parameters.
module tb_multi_servo_uart_ctrl;

  localparam int NCH   = 4;
  localparam int BT    = 16;    // 1600 Hz / 100 baud
  localparam int PP    = 2000;
  localparam int PMIN  = 100;
  localparam int PSTEP = 4;
  localparam int SDIV  = 8;
  localparam int CTR   = 128;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           uart_rx = 1'b1;
  logic [NCH-1:0] pwm;
  logic           cmd_valid;
  logic           frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_cmd = 0;
  int n_err = 0;
  int last_cmd_cyc = 0;
  int meas[NCH];
  int rise_cyc = 0;

  multi_servo_uart_ctrl #(
    .CLK_FREQ  (1600),
    .BAUD_RATE (100),
    .NUM_CH    (NCH),
    .PWM_PERIOD(PP),
    .PULSE_MIN (PMIN),
    .PULSE_STEP(PSTEP),
    .SLEW_DIV  (SDIV),
    .CENTER    (CTR)
  ) dut (
    .clk50mhz     (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .servo_pwm_out(pwm),
    .cmd_valid    (cmd_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      n_cmd++;
      last_cmd_cyc = cyc;
    end
    if (frame_err === 1'b1) n_err++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rx = fr[k];
      repeat (BT) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (2 * BT) @(negedge clk);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
  endtask

  // Waits for a fresh frame start and counts high cycles of every channel in that frame.
  task automatic measure_all();
    int t;
    for (int c = 0; c < NCH; c++) meas[c] = 0;
    t = 0;
    while (pwm !== '0 && t < 3 * PP) begin @(negedge clk); t++; end
    while (pwm[0] !== 1'b1 && t < 3 * PP) begin @(negedge clk); t++; end
    if (t >= 3 * PP) begin
      checks++;
      failures++;
      $display("FAIL measure_timeout got=%0d exp=<%0d", t, 3 * PP);
    end else begin
      rise_cyc = cyc;
      t = 0;
      do begin
        for (int c = 0; c < NCH; c++) if (pwm[c] === 1'b1) meas[c]++;
        @(negedge clk);
        t++;
      end while (pwm !== '0 && t < PP);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (pwm !== '0) begin failures++; $display("FAIL rst_pwm got=%b exp=0", pwm); end
    checks++;
    if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_cmd_valid got=%b exp=0", cmd_valid); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_center_width();
    int r1;
    measure_all();
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (meas[c] !== PMIN + CTR * PSTEP) begin
        failures++;
        $display("FAIL center_width ch%0d got=%0d exp=%0d", c, meas[c], PMIN + CTR * PSTEP);
      end
    end
    r1 = rise_cyc;
    measure_all();
    checks++;
    if (rise_cyc - r1 !== PP) begin
      failures++;
      $display("FAIL pwm_period got=%0d exp=%0d", rise_cyc - r1, PP);
    end
    $display("test_center_width widths=%0d,%0d,%0d,%0d", meas[0], meas[1], meas[2], meas[3]);
  endtask

  task automatic test_resync_update();
    int c0, e0;
    c0 = n_cmd; e0 = n_err;
    send3(8'hFF, 8'h02, 8'hFF);
    checks++;
    if (n_cmd !== c0 || n_err !== e0) begin
      failures++;
      $display("FAIL resync_no_update got=cmd%0d/err%0d exp=cmd%0d/err%0d", n_cmd, n_err, c0, e0);
    end
    send_byte(8'h02, 1'b1);
    send_byte(8'hC8, 1'b1);
    repeat (800) @(negedge clk);
    checks++;
    if (n_cmd !== c0 + 1) begin failures++; $display("FAIL ch2_cmd_once got=%0d exp=%0d", n_cmd - c0, 1); end
    measure_all();
    checks++;
    if (meas[2] !== 900) begin failures++; $display("FAIL ch2_width got=%0d exp=900", meas[2]); end
    checks++;
    if (meas[0] !== 612) begin failures++; $display("FAIL ch0_untouched got=%0d exp=612", meas[0]); end
    $display("test_resync_update ch2=%0d ch0=%0d", meas[2], meas[0]);
  endtask

  task automatic test_bad_channel();
    int c0, e0;
    c0 = n_cmd; e0 = n_err;
    send3(8'hFF, 8'h07, 8'h10);
    checks++;
    if (n_err !== e0 + 1) begin failures++; $display("FAIL badch_err got=%0d exp=1", n_err - e0); end
    checks++;
    if (n_cmd !== c0) begin failures++; $display("FAIL badch_cmd got=%0d exp=0", n_cmd - c0); end
    measure_all();
    checks++;
    if (meas[2] !== 900 || meas[1] !== 612) begin
      failures++;
      $display("FAIL badch_widths got=%0d/%0d exp=900/612", meas[2], meas[1]);
    end
    $display("test_bad_channel err_delta=%0d", n_err - e0);
  endtask

  task automatic test_boundary_channel();
    int c0;
    c0 = n_cmd;
    send3(8'hFF, 8'h03, 8'h40);
    checks++;
    if (n_cmd !== c0 + 1) begin failures++; $display("FAIL ch3_cmd got=%0d exp=1", n_cmd - c0); end
    repeat (600) @(negedge clk);
    measure_all();
    checks++;
    if (meas[3] !== 356) begin failures++; $display("FAIL ch3_width got=%0d exp=356", meas[3]); end
    $display("test_boundary_channel ch3=%0d", meas[3]);
  endtask

  task automatic test_broadcast();
    int c0, e0;
    c0 = n_cmd; e0 = n_err;
    send3(8'hFF, 8'hFE, 8'h00);
    checks++;
    if (n_cmd !== c0 + 1 || n_err !== e0) begin
      failures++;
      $display("FAIL bcast_cmd got=cmd%0d/err%0d exp=cmd1/err0", n_cmd - c0, n_err - e0);
    end
    repeat (2000) @(negedge clk);
    measure_all();
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (meas[c] !== PMIN) begin failures++; $display("FAIL bcast_width ch%0d got=%0d exp=%0d", c, meas[c], PMIN); end
    end
    $display("test_broadcast widths=%0d,%0d,%0d,%0d", meas[0], meas[1], meas[2], meas[3]);
  endtask

  task automatic test_midpulse_update();
    int c0, r, f, t;
    send3(8'hFF, 8'h01, 8'hFE);
    repeat (2200) @(negedge clk);
    measure_all();
    checks++;
    if (meas[1] !== 1116) begin failures++; $display("FAIL ch1_max_width got=%0d exp=1116", meas[1]); end
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    c0 = n_cmd;
    t = 0;
    while (pwm !== '0 && t < 3 * PP) begin @(negedge clk); t++; end
    while (pwm[1] !== 1'b1 && t < 3 * PP) begin @(negedge clk); t++; end
    r = cyc;
    send_byte(8'h00, 1'b1);
    while (pwm[1] !== 1'b0 && t < 3 * PP) begin @(negedge clk); t++; end
    f = cyc;
    checks++;
    if (t >= 3 * PP) begin failures++; $display("FAIL midpulse_timeout got=%0d exp=<%0d", t, 3 * PP); end
    checks++;
    if (n_cmd !== c0 + 1 || last_cmd_cyc <= r || last_cmd_cyc >= f) begin
      failures++;
      $display("FAIL midpulse_cmd_in_pulse got=cyc%0d exp=in(%0d,%0d)", last_cmd_cyc, r, f);
    end
    checks++;
    if (f - r !== 1116) begin failures++; $display("FAIL midpulse_width got=%0d exp=1116", f - r); end
    $display("test_midpulse_update width=%0d", f - r);
  endtask

  task automatic test_stop_err_and_glitch();
    int c0, e0;
    c0 = n_cmd; e0 = n_err;
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h20, 1'b1);
    checks++;
    if (n_err !== e0 + 1) begin failures++; $display("FAIL stop_err got=%0d exp=1", n_err - e0); end
    checks++;
    if (n_cmd !== c0) begin failures++; $display("FAIL stop_err_hunt got=%0d exp=0", n_cmd - c0); end
    uart_rx = 1'b0;
    repeat (BT / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (10 * BT) @(negedge clk);
    checks++;
    if (n_err !== e0 + 1 || n_cmd !== c0) begin
      failures++;
      $display("FAIL glitch_silent got=cmd%0d/err%0d exp=cmd0/err1", n_cmd - c0, n_err - e0);
    end
    send3(8'hFF, 8'h00, 8'h10);
    checks++;
    if (n_cmd !== c0 + 1) begin failures++; $display("FAIL after_glitch_cmd got=%0d exp=1", n_cmd - c0); end
    $display("test_stop_err_and_glitch err_delta=%0d cmd_delta=%0d", n_err - e0, n_cmd - c0);
  endtask

  task automatic test_reset_midframe();
    int c0, e0;
    send_byte(8'hFF, 1'b1);
    send_byte(8'h03, 1'b1);
    uart_rx = 1'b0;
    repeat (3 * BT) @(negedge clk);
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pwm !== '0 || cmd_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs got=%b/%b/%b exp=0/0/0", pwm, cmd_valid, frame_err);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c0 = n_cmd; e0 = n_err;
    repeat (300) @(negedge clk);
    send_byte(8'h40, 1'b1);
    checks++;
    if (n_cmd !== c0 || n_err !== e0) begin
      failures++;
      $display("FAIL midrst_no_pulse got=cmd%0d/err%0d exp=cmd0/err0", n_cmd - c0, n_err - e0);
    end
    measure_all();
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (meas[c] !== 612) begin failures++; $display("FAIL midrst_width ch%0d got=%0d exp=612", c, meas[c]); end
    end
    $display("test_reset_midframe widths=%0d,%0d,%0d,%0d", meas[0], meas[1], meas[2], meas[3]);
  endtask

  initial begin
    test_reset();
    test_center_width();
    test_resync_update();
    test_bad_channel();
    test_boundary_channel();
    test_broadcast();
    test_midpulse_update();
    test_stop_err_and_glitch();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
